// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types, sizes and helper functions for the round-robin grant arbiter.
// Holds the state encoding, the rotating priority pick and the 3-to-8 decode.
package rr_decoder_arbiter_pkg;

   localparam int NUM_REQ = 16;
   localparam int IDX_W   = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // First set request at or after last_ptr+1, wrapping 15->0.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [IDX_W-1:0]   last_ptr);
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      logic [IDX_W-1:0]     start;
      logic [IDX_W-1:0]     off;
      start = last_ptr + 4'd1;
      dbl   = {req, req} >> start;
      rot   = dbl[NUM_REQ-1:0];
      off   = 4'd0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
         end else begin
            off = off;
         end
      end
      return start + off;
   endfunction

   function automatic logic [7:0] dec3to8(input logic [2:0] sel);
      return 8'h01 << sel;
   endfunction

endpackage

// File: rtl/rr_decoder_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
import rr_decoder_arbiter_pkg::*;

interface rr_decoder_arbiter_if;
   logic               en_n;
   logic [NUM_REQ-1:0] req;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt_onehot;
   logic               timeout_pulse;
   logic               busy;

   modport master (
      output en_n, req,
      input  gnt_valid, gnt_idx, gnt_onehot, timeout_pulse, busy
   );

   modport slave (
      input  en_n, req,
      output gnt_valid, gnt_idx, gnt_onehot, timeout_pulse, busy
   );
endinterface

// File: rtl/rr_decoder_arbiter_decoder_4to16_en.sv
// 4-to-16 one-hot decoder with active-low enable, built from two 3-to-8 halves
// selected by the index MSB.
module decoder_4to16_en
   import rr_decoder_arbiter_pkg::*;
(
   input  logic [IDX_W-1:0]   idx,
   input  logic               en_n,
   output logic [NUM_REQ-1:0] onehot
);

   logic [7:0] lo_s;
   logic [7:0] hi_s;

   // Route the 3-to-8 decode to the half picked by idx[3].
   always_comb begin
      lo_s = 8'h00;
      hi_s = 8'h00;
      if (!en_n) begin
         if (idx[3]) begin
            hi_s = dec3to8(idx[2:0]);
         end else begin
            lo_s = dec3to8(idx[2:0]);
         end
      end else begin
         lo_s = 8'h00;
         hi_s = 8'h00;
      end
   end

   assign onehot = {hi_s, lo_s};

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter for 16 requesters with hold limit and a one-cycle
// turnaround between owners; the one-hot grant comes from the registered index.
module rr_decoder_arbiter
   import rr_decoder_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 64,
   parameter int unsigned HOLD_W   = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   rr_decoder_arbiter_if.slave  bus
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

   state_e             state_r, state_nxt_s;
   logic               gnt_valid_r, gnt_valid_nxt_s;
   logic [IDX_W-1:0]   gnt_idx_r, gnt_idx_nxt_s;
   logic [IDX_W-1:0]   last_ptr_r, last_ptr_nxt_s;
   logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_nxt_s;
   logic               timeout_r, timeout_nxt_s;
   logic               busy_r;
   logic               owner_req_s;
   logic               hold_lim_s;
   logic               dec_en_n_s;

   assign owner_req_s = bus.req[gnt_idx_r];
   assign hold_lim_s  = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST);

   // Next-state and next-output decisions for the IDLE/GRANT controller.
   always_comb begin
      state_nxt_s     = state_r;
      gnt_valid_nxt_s = gnt_valid_r;
      gnt_idx_nxt_s   = gnt_idx_r;
      last_ptr_nxt_s  = last_ptr_r;
      hold_cnt_nxt_s  = hold_cnt_r;
      timeout_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!bus.en_n && (|bus.req)) begin
               state_nxt_s     = GRANT;
               gnt_valid_nxt_s = 1'b1;
               gnt_idx_nxt_s   = rr_pick(bus.req, last_ptr_r);
               hold_cnt_nxt_s  = '0;
            end else begin
               gnt_valid_nxt_s = 1'b0;
               gnt_idx_nxt_s   = 4'd0;
               hold_cnt_nxt_s  = '0;
            end
         end
         GRANT: begin
            if (!owner_req_s || hold_lim_s) begin
               // A simultaneous drop and hold limit counts as a normal release.
               state_nxt_s     = IDLE;
               gnt_valid_nxt_s = 1'b0;
               gnt_idx_nxt_s   = 4'd0;
               last_ptr_nxt_s  = gnt_idx_r;
               hold_cnt_nxt_s  = '0;
               timeout_nxt_s   = hold_lim_s && owner_req_s;
            end else if (hold_cnt_r != {HOLD_W{1'b1}}) begin
               hold_cnt_nxt_s  = hold_cnt_r + HOLD_W'(1);
            end else begin
               hold_cnt_nxt_s  = hold_cnt_r;
            end
         end
         default: begin
            state_nxt_s     = IDLE;
            gnt_valid_nxt_s = 1'b0;
            gnt_idx_nxt_s   = 4'd0;
            hold_cnt_nxt_s  = '0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         gnt_valid_r <= 1'b0;
         gnt_idx_r   <= 4'd0;
         last_ptr_r  <= 4'd15;
         hold_cnt_r  <= '0;
         timeout_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         gnt_valid_r <= gnt_valid_nxt_s;
         gnt_idx_r   <= gnt_idx_nxt_s;
         last_ptr_r  <= last_ptr_nxt_s;
         hold_cnt_r  <= hold_cnt_nxt_s;
         timeout_r   <= timeout_nxt_s;
         busy_r      <= (state_nxt_s == GRANT);
      end
   end

   assign dec_en_n_s = ~gnt_valid_r;

   decoder_4to16_en u_dec (
      .idx    (gnt_idx_r),
      .en_n   (dec_en_n_s),
      .onehot (bus.gnt_onehot)
   );

   assign bus.gnt_valid     = gnt_valid_r;
   assign bus.gnt_idx       = gnt_idx_r;
   assign bus.timeout_pulse = timeout_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench for rr_decoder_arbiter: default-limit instance (a) and a
// MAX_HOLD=4 instance (b); per-cycle expectations go through a scoreboard queue.
module tb_rr_decoder_arbiter;

   logic clk;
   logic rst;

   rr_decoder_arbiter_if ifa ();
   rr_decoder_arbiter_if ifb ();

   rr_decoder_arbiter dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   rr_decoder_arbiter #(.MAX_HOLD(4), .HOLD_W(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   typedef struct {
      string       tag;
      bit          use_b;
      logic        v;
      logic [3:0]  idx;
      logic        to;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge, then check.
   task automatic step(input bit use_b, input logic [15:0] r, input logic e_n,
                       input logic ev, input logic [3:0] ei, input logic eto,
                       input string tag);
      exp_t        e;
      logic [15:0] eoh;
      if (use_b) begin
         ifb.req = r;       ifb.en_n = e_n;
         ifa.req = 16'h0000; ifa.en_n = 1'b1;
      end else begin
         ifa.req = r;       ifa.en_n = e_n;
         ifb.req = 16'h0000; ifb.en_n = 1'b1;
      end
      sb.push_back('{tag: tag, use_b: use_b, v: ev, idx: ei, to: eto});
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      eoh = e.v ? (16'h0001 << e.idx) : 16'h0000;
      if (e.use_b) begin
         chk({e.tag, ".valid"},   {15'd0, ifb.gnt_valid},     {15'd0, e.v});
         chk({e.tag, ".idx"},     {12'd0, ifb.gnt_idx},       {12'd0, e.idx});
         chk({e.tag, ".onehot"},  ifb.gnt_onehot,             eoh);
         chk({e.tag, ".timeout"}, {15'd0, ifb.timeout_pulse}, {15'd0, e.to});
         chk({e.tag, ".busy"},    {15'd0, ifb.busy},          {15'd0, e.v});
      end else begin
         chk({e.tag, ".valid"},   {15'd0, ifa.gnt_valid},     {15'd0, e.v});
         chk({e.tag, ".idx"},     {12'd0, ifa.gnt_idx},       {12'd0, e.idx});
         chk({e.tag, ".onehot"},  ifa.gnt_onehot,             eoh);
         chk({e.tag, ".timeout"}, {15'd0, ifa.timeout_pulse}, {15'd0, e.to});
         chk({e.tag, ".busy"},    {15'd0, ifa.busy},          {15'd0, e.v});
      end
   endtask

   initial begin
      int owners[5];
      owners = '{0, 5, 10, 15, 0};
      rst = 1'b1;
      ifa.req = 16'h0000; ifa.en_n = 1'b0;
      ifb.req = 16'h0000; ifb.en_n = 1'b0;

      // Reset, then quiet idle.
      step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "reset");
      step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "reset");
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "idle");

      // Single requester: grant after one cycle, release one cycle after drop.
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0001, 1'b0, 1'b1, 4'd0, 1'b0, "single");
      step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "single_rel");
      step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "single_idle");

      // Round robin over 8421 from a fresh pointer; 3 grant cycles + 1 gap each.
      rst = 1'b1;
      step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "reset2");
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 3; c++)
            step(1'b0, 16'h8421, 1'b0, 1'b1, 4'(owners[k]), 1'b0, "rr_grant");
         step(1'b0, 16'h8421 & ~(16'h0001 << owners[k]), 1'b0, 1'b0, 4'd0, 1'b0, "rr_gap");
      end

      // Enable gating: nothing while disabled; disabling mid-grant lets owner finish.
      for (int i = 0; i < 3; i++) step(1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, "en_off");
      step(1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd1, 1'b0, "en_grant");
      step(1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd1, 1'b0, "en_mid");
      step(1'b0, 16'hFFFF, 1'b1, 1'b1, 4'd1, 1'b0, "en_mid");
      step(1'b0, 16'hFFFD, 1'b1, 1'b0, 4'd0, 1'b0, "en_rel");
      for (int i = 0; i < 3; i++) step(1'b0, 16'hFFFF, 1'b1, 1'b0, 4'd0, 1'b0, "en_hold_off");
      step(1'b0, 16'hFFFF, 1'b0, 1'b1, 4'd2, 1'b0, "en_back");
      step(1'b0, 16'hFFFB, 1'b0, 1'b0, 4'd0, 1'b0, "en_back_rel");

      // Reset during a grant of requester 7, then re-grant after reset release.
      step(1'b0, 16'h0080, 1'b0, 1'b1, 4'd7, 1'b0, "g7");
      step(1'b0, 16'h0080, 1'b0, 1'b1, 4'd7, 1'b0, "g7");
      rst = 1'b1;
      step(1'b0, 16'h0080, 1'b0, 1'b0, 4'd0, 1'b0, "g7_rst");
      rst = 1'b0;
      step(1'b0, 16'h0080, 1'b0, 1'b1, 4'd7, 1'b0, "g7_after");
      step(1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "g7_rel");

      // Hold limit of 4 on instance b: alternating timeouts between 0 and 1.
      rst = 1'b1;
      step(1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "b_reset");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0003, 1'b0, 1'b1, 4'd0, 1'b0, "b_to_g0");
      step(1'b1, 16'h0003, 1'b0, 1'b0, 4'd0, 1'b1, "b_to_gap0");
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0003, 1'b0, 1'b1, 4'd1, 1'b0, "b_to_g1");
      step(1'b1, 16'h0003, 1'b0, 1'b0, 4'd0, 1'b1, "b_to_gap1");
      step(1'b1, 16'h0003, 1'b0, 1'b1, 4'd0, 1'b0, "b_to_g0b");
      step(1'b1, 16'h0002, 1'b0, 1'b0, 4'd0, 1'b0, "b_drop0");

      // Drop coinciding with the hold limit: plain release, no pulse.
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0, "b_both_g");
      step(1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "b_both_rel");

      // Sole requester timing out is re-granted after the single gap cycle.
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0, "b_sole_g");
      step(1'b1, 16'h0004, 1'b0, 1'b0, 4'd0, 1'b1, "b_sole_gap");
      step(1'b1, 16'h0004, 1'b0, 1'b1, 4'd2, 1'b0, "b_sole_regrant");
      step(1'b1, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "b_sole_rel");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
